// File: rtl/tia_pkg.sv
// Shared TIA counter definitions: LFSR feedback taps, step function and decode states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
//
// The decode constants are derived from the step function at elaboration time, so
// the object and playfield counters can reuse them without hand-computed encodings.
package tia_pkg;

   localparam int HC_W     = 6;

   // Feedback taps: the new LSB is the XNOR of these two state bits.
   localparam int HC_TAP_A = 5;
   localparam int HC_TAP_B = 4;

   // One counter step. XNOR feedback makes 000000 a legal state and 111111 the lock-up state.
   function automatic logic [HC_W-1:0] hc_step(input logic [HC_W-1:0] s);
      return {s[HC_W-2:0], ~(s[HC_TAP_A] ^ s[HC_TAP_B])};
   endfunction

   // State reached after 'idx' steps from 000000.
   function automatic logic [HC_W-1:0] hc_at(input int idx);
      logic [HC_W-1:0] s;
      s = '0;
      for (int i = 0; i < idx; i++) begin
         s = hc_step(s);
      end
      return s;
   endfunction

   localparam logic [HC_W-1:0] HC_WRAP    = hc_at(56);
   localparam logic [HC_W-1:0] HC_HSSTART = hc_at(4);
   localparam logic [HC_W-1:0] HC_HSEND   = hc_at(8);
   localparam logic [HC_W-1:0] HC_HBEND   = hc_at(17);

endpackage

// File: rtl/tia_hsync_poly6.sv
// 6-bit polynomial (LFSR) counter with step enable, synchronous clear and wrap detect.
// Latency: count updates one clk after step/clear; wrap and count_nxt are combinational from count.
// Backpressure: none; step is a free-running enable from the caller.
//
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   clear        - synchronous restart to 000000 (lower priority than nothing; same as reset)
//   step         - advance one state on this edge
//   count        - current state
//   count_nxt    - state that the next step will load (000000 after the wrap state)
//   wrap         - count is the last state of the line
module tia_poly6
   import tia_pkg::*;
#(
   parameter logic [HC_W-1:0] WRAP = HC_WRAP
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            step,
   output logic [HC_W-1:0] count,
   output logic [HC_W-1:0] count_nxt,
   output logic            wrap
);

   always_comb begin
      wrap      = (count == WRAP);
      count_nxt = wrap ? '0 : hc_step(count);
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (step) begin
         count <= count_nxt;
      end
   end

endmodule

// File: rtl/tia_hsync.sv
// Horizontal sync generator: 4-phase clock divider, polynomial line counter, hblank/hsync/line_end decode.
// Latency: phi1/phi2 combinational from registered div; decode outputs registered on counter-step edges.
// Backpressure: none; free-running, restarted only by reset or rsync.
//
// Ports:
//   clk      - color clock          reset    - synchronous active-high reset
//   rsync    - restart line strobe  phi1     - div==1 phase pulse
//   phi2     - div==3 phase pulse   hcount   - current counter state
//   hblank   - blank window         hsync    - sync window
//   line_end - one-clk pulse after the wrap step
module tia_hsync
   import tia_pkg::*;
#(
   parameter int HC_LEN = 57
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            rsync,
   output logic            phi1,
   output logic            phi2,
   output logic [HC_W-1:0] hcount,
   output logic            hblank,
   output logic            hsync,
   output logic            line_end
);

   localparam logic [HC_W-1:0] WRAP_ST = hc_at(HC_LEN - 1);

   logic [1:0]      div;
   logic            step;
   logic [HC_W-1:0] hc_nxt;
   logic            hc_wrap;
   logic            hblank_d;
   logic            hsync_d;

   // The counter steps on the same edge that ends the phi2 phase.
   assign step = (div == 2'd3);
   assign phi1 = (div == 2'd1);
   assign phi2 = (div == 2'd3);

   tia_poly6 #(
      .WRAP (WRAP_ST)
   ) u_poly (
      .clk       (clk),
      .reset     (reset),
      .clear     (rsync),
      .step      (step),
      .count     (hcount),
      .count_nxt (hc_nxt),
      .wrap      (hc_wrap)
   );

   // Window flags are set/cleared by the state being entered, and otherwise hold.
   always_comb begin
      hblank_d = hblank;
      hsync_d  = hsync;
      if (hc_nxt == '0) begin
         hblank_d = 1'b1;
      end else if (hc_nxt == HC_HBEND) begin
         hblank_d = 1'b0;
      end
      if (hc_nxt == HC_HSSTART) begin
         hsync_d = 1'b1;
      end else if (hc_nxt == HC_HSEND) begin
         hsync_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || rsync) begin
         div      <= 2'd0;
         hblank   <= 1'b1;
         hsync    <= 1'b0;
         line_end <= 1'b0;
      end else begin
         div      <= div + 2'd1;
         line_end <= 1'b0;
         if (step) begin
            hblank   <= hblank_d;
            hsync    <= hsync_d;
            line_end <= hc_wrap;
         end
      end
   end

endmodule

// File: tb/tb_tia_hsync.sv
module tb_tia_hsync;

   logic       clk = 1'b0;
   logic       reset;
   logic       rsync;
   logic       phi1, phi2, hblank, hsync, line_end;
   logic [5:0] hcount;

   always #5 clk = ~clk;

   tia_hsync #(.HC_LEN(57)) dut (
      .clk      (clk),
      .reset    (reset),
      .rsync    (rsync),
      .phi1     (phi1),
      .phi2     (phi2),
      .hcount   (hcount),
      .hblank   (hblank),
      .hsync    (hsync),
      .line_end (line_end)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: position within the 228-clk line since the last restart.
   int         t;
   bit         mle;
   logic [5:0] seq [57];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", nm, act, exp, t);
      end
   endtask

   task automatic check_model();
      chk("m_phi1",  {31'd0, phi1},  {31'd0, (t % 4) == 1});
      chk("m_phi2",  {31'd0, phi2},  {31'd0, (t % 4) == 3});
      chk("m_hcount", {26'd0, hcount}, {26'd0, seq[t / 4]});
      chk("m_hblank", {31'd0, hblank}, {31'd0, (t / 4) < 17});
      chk("m_hsync",  {31'd0, hsync},  {31'd0, ((t / 4) >= 4) && ((t / 4) < 8)});
      chk("m_line_end", {31'd0, line_end}, {31'd0, mle});
      if (phi1 && phi2) chk("overlap", 32'd1, 32'd0);
   endtask

   task automatic tick(input logic r, input logic rs);
      reset = r;
      rsync = rs;
      @(posedge clk);
      #1;
      if (r || rs) begin
         t   = 0;
         mle = 1'b0;
      end else begin
         t   = (t + 1) % 228;
         mle = (t == 0);
      end
      check_model();
   endtask

   typedef struct packed {
      logic       rst;
      logic       rs;
      logic       p1;
      logic       p2;
      logic [5:0] hc;
      logic       hb;
      logic       hs;
      logic       le;
   } vec_t;

   vec_t vecs [16];

   initial begin
      int         pulses, first_le, second_le, distinct, hb_cnt, hs_cnt, hs_rise;
      bit         seen [64];
      logic [5:0] s;

      reset = 1'b1;
      rsync = 1'b0;
      t     = 0;
      mle   = 1'b0;

      // Sequence table from the step rule, wrapping to 0 after index 56.
      s = 6'd0;
      for (int i = 0; i < 57; i++) begin
         seq[i] = s;
         s = {s[4:0], ~(s[5] ^ s[4])};
      end

      //             rst   rs    p1    p2    hc     hb    hs    le
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'h00, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h01, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 6'h01, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h03, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h03, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h03, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'h03, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'h07, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 1'b1, 1'b0, 1'b0};

      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);

      // Table: reset then first 12 clks, rsync restart, reset+rsync.
      for (int i = 0; i < 16; i++) begin
         tick(vecs[i].rst, vecs[i].rs);
         chk("v_phi1",   {31'd0, phi1},     {31'd0, vecs[i].p1});
         chk("v_phi2",   {31'd0, phi2},     {31'd0, vecs[i].p2});
         chk("v_hcount", {26'd0, hcount},   {26'd0, vecs[i].hc});
         chk("v_hblank", {31'd0, hblank},   {31'd0, vecs[i].hb});
         chk("v_hsync",  {31'd0, hsync},    {31'd0, vecs[i].hs});
         chk("v_le",     {31'd0, line_end}, {31'd0, vecs[i].le});
      end

      // Free run of two lines.
      tick(1'b1, 1'b0);
      pulses = 0; first_le = -1; second_le = -1; distinct = 0;
      for (int i = 0; i < 64; i++) seen[i] = 1'b0;
      seen[hcount] = 1'b1;
      for (int c = 1; c <= 456; c++) begin
         tick(1'b0, 1'b0);
         if (line_end) begin
            pulses++;
            if (first_le < 0) first_le = c;
            else second_le = c;
         end
         if (c < 228) seen[hcount] = 1'b1;
         if (c == 228) chk("wrap_to_zero", {26'd0, hcount}, 32'd0);
      end
      for (int i = 0; i < 64; i++) if (seen[i]) distinct++;
      chk("le_pulses", pulses, 2);
      chk("le_first", first_le, 228);
      chk("le_spacing", second_le - first_le, 228);
      chk("distinct_states", distinct, 57);

      // Blank and sync window widths from line start.
      tick(1'b1, 1'b0);
      hb_cnt = hblank ? 1 : 0;
      hs_cnt = hsync ? 1 : 0;
      hs_rise = -1;
      for (int c = 1; c < 228; c++) begin
         tick(1'b0, 1'b0);
         if (hblank) hb_cnt++;
         if (hsync) begin
            hs_cnt++;
            if (hs_rise < 0) hs_rise = c;
         end
      end
      chk("hblank_width", hb_cnt, 68);
      chk("hsync_rise", hs_rise, 16);
      chk("hsync_width", hs_cnt, 16);

      // rsync at index 30, div 2.
      tick(1'b1, 1'b0);
      for (int c = 0; c < 122; c++) tick(1'b0, 1'b0);
      chk("pre_rsync_hc", {26'd0, hcount}, {26'd0, seq[30]});
      tick(1'b0, 1'b1);
      chk("rsync_hc", {26'd0, hcount}, 32'd0);
      chk("rsync_hb", {31'd0, hblank}, 32'd1);
      chk("rsync_le", {31'd0, line_end}, 32'd0);
      chk("rsync_phi", {30'd0, phi1, phi2}, 32'd0);
      tick(1'b0, 1'b0);
      chk("rsync_next_phi1", {31'd0, phi1}, 32'd1);

      // rsync on the wrap edge.
      tick(1'b1, 1'b0);
      for (int c = 0; c < 227; c++) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      chk("wrap_rsync_le", {31'd0, line_end}, 32'd0);
      chk("wrap_rsync_hc", {26'd0, hcount}, 32'd0);
      tick(1'b0, 1'b0);
      chk("wrap_rsync_le2", {31'd0, line_end}, 32'd0);

      // Reset held 3 clks at index 6, then the startup trace again.
      tick(1'b1, 1'b0);
      for (int c = 0; c < 24; c++) tick(1'b0, 1'b0);
      chk("idx6_hsync", {31'd0, hsync}, 32'd1);
      for (int c = 0; c < 3; c++) tick(1'b1, 1'b0);
      chk("rst_hsync", {31'd0, hsync}, 32'd0);
      chk("rst_hblank", {31'd0, hblank}, 32'd1);
      chk("rst_hcount", {26'd0, hcount}, 32'd0);
      for (int c = 0; c < 12; c++) tick(1'b0, 1'b0);
      chk("rst_trace_hc", {26'd0, hcount}, 32'h07);

      // Randomized run with sporadic rsync and reset.
      for (int c = 0; c < 4000; c++) begin
         tick(($urandom_range(0, 499) == 0), ($urandom_range(0, 149) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
